// File: rtl/e2prom_rw_test.sv
`default_nettype none
// ============================================================================
// e2prom_rw_test : E2PROM self-test sequencer (write pattern, read back, compare)
// Rev 1.0
// ============================================================================
module e2prom_rw_test #(
    parameter int unsigned BYTE_NUM    = 256,
    parameter int unsigned WR_WAIT_MAX = 5000,
    parameter int unsigned START_DLY   = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        rw_done,
    output logic        rw_result
);

    localparam logic [16:0] C_LAST_CNT    = 17'(BYTE_NUM - 1);
    localparam logic [13:0] C_WR_WAIT_END = 14'(WR_WAIT_MAX - 1);
    localparam logic [13:0] C_START_END   = 14'(START_DLY - 1);

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_WR_GAP  = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_PASS    = 3'd6,
        ST_FAIL    = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [13:0] dly_q, dly_d;
    logic        exec_q, exec_d;
    logic        rh_wl_q, rh_wl_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_w_q, data_w_d;
    logic        rw_done_q, rw_done_d;
    logic        rw_result_q, rw_result_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dly_d       = dly_q;
        exec_d      = 1'b0;
        rh_wl_d     = rh_wl_q;
        addr_d      = addr_q;
        data_w_d    = data_w_q;
        rw_done_d   = 1'b0;
        rw_result_d = rw_result_q;

        case (state_q)
            ST_START: begin
                if (dly_q == C_START_END) state_d = ST_WR_REQ;
                else                      dly_d   = dly_q + 14'd1;
            end
            ST_WR_REQ: begin
                exec_d   = 1'b1;
                rh_wl_d  = 1'b0;
                addr_d   = cnt_q[15:0];
                data_w_d = cnt_q[7:0];
                state_d  = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (i2c_done) begin
                    if (i2c_ack) begin
                        state_d     = ST_FAIL;
                        rw_done_d   = 1'b1;
                        rw_result_d = 1'b0;
                    end else begin
                        state_d = ST_WR_GAP;
                    end
                end
            end
            ST_WR_GAP: begin
                // Gap covers the device's internal write cycle before the next access
                if (dly_q == C_WR_WAIT_END) begin
                    if (cnt_q == C_LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_RD_REQ;
                    end else begin
                        cnt_d   = cnt_q + 17'd1;
                        state_d = ST_WR_REQ;
                    end
                end else begin
                    dly_d = dly_q + 14'd1;
                end
            end
            ST_RD_REQ: begin
                exec_d  = 1'b1;
                rh_wl_d = 1'b1;
                addr_d  = cnt_q[15:0];
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (i2c_done) begin
                    if (i2c_ack || (i2c_data_r != cnt_q[7:0])) begin
                        state_d     = ST_FAIL;
                        rw_done_d   = 1'b1;
                        rw_result_d = 1'b0;
                    end else if (cnt_q == C_LAST_CNT) begin
                        state_d     = ST_PASS;
                        rw_done_d   = 1'b1;
                        rw_result_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 17'd1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_PASS, ST_FAIL: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        if (state_d != state_q) dly_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_START;
            cnt_q       <= '0;
            dly_q       <= '0;
            exec_q      <= 1'b0;
            rh_wl_q     <= 1'b0;
            addr_q      <= '0;
            data_w_q    <= '0;
            rw_done_q   <= 1'b0;
            rw_result_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            exec_q      <= exec_d;
            rh_wl_q     <= rh_wl_d;
            addr_q      <= addr_d;
            data_w_q    <= data_w_d;
            rw_done_q   <= rw_done_d;
            rw_result_q <= rw_result_d;
        end
    end

    assign i2c_exec   = exec_q;
    assign i2c_rh_wl  = rh_wl_q;
    assign i2c_addr   = addr_q;
    assign i2c_data_w = data_w_q;
    assign rw_done    = rw_done_q;
    assign rw_result  = rw_result_q;

endmodule
`default_nettype wire

// File: tb/tb_e2prom_rw_test.sv
`default_nettype none
// ============================================================================
// tb_e2prom_rw_test : bench for e2prom_rw_test with a behavioural I2C/E2PROM model
// Rev 1.0
// ============================================================================
module tb_e2prom_rw_test;

    localparam int LAT       = 20;
    localparam int WR_WAIT   = 10;
    localparam int START     = 5;
    localparam int MODE_OK   = 0;
    localparam int MODE_MISM = 1;
    localparam int MODE_NACK = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        i_exec    [2];
    logic        i_rh_wl   [2];
    logic [15:0] i_addr    [2];
    logic [7:0]  i_data_w  [2];
    logic [7:0]  i_data_r  [2];
    logic        i_done    [2];
    logic        i_ack     [2];
    logic        rw_done   [2];
    logic        rw_result [2];

    e2prom_rw_test #(.BYTE_NUM(4), .WR_WAIT_MAX(WR_WAIT), .START_DLY(START)) u_dut_a (
        .clk(clk), .rst_n(rst_n[0]),
        .i2c_exec(i_exec[0]), .i2c_rh_wl(i_rh_wl[0]), .i2c_addr(i_addr[0]),
        .i2c_data_w(i_data_w[0]), .i2c_data_r(i_data_r[0]), .i2c_done(i_done[0]),
        .i2c_ack(i_ack[0]), .rw_done(rw_done[0]), .rw_result(rw_result[0])
    );

    e2prom_rw_test #(.BYTE_NUM(1), .WR_WAIT_MAX(WR_WAIT), .START_DLY(START)) u_dut_b (
        .clk(clk), .rst_n(rst_n[1]),
        .i2c_exec(i_exec[1]), .i2c_rh_wl(i_rh_wl[1]), .i2c_addr(i_addr[1]),
        .i2c_data_w(i_data_w[1]), .i2c_data_r(i_data_r[1]), .i2c_done(i_done[1]),
        .i2c_ack(i_ack[1]), .rw_done(rw_done[1]), .rw_result(rw_result[1])
    );

    typedef struct {
        int rh;
        int addr;
        int data;
        int cyc;
    } txn_t;

    typedef struct {
        int rh;
        int addr;
        int data;   // -1: not compared
    } vec_t;

    int          checks;
    int          errors;
    int          cyc;
    int          mode      [2];
    bit          spur_en   [2];
    int          spur_at   [2];
    int          spur_seen [2];
    logic [7:0]  mem       [2][4];
    bit          busy      [2];
    int          tmr       [2];
    int          cur_rh    [2];
    int          cur_addr  [2];
    logic [7:0]  cur_data  [2];
    int          nwr       [2];
    bit          exec_prev [2];
    bit          rwd_prev  [2];
    bit          hold_bad  [2];
    logic        held_rh   [2];
    logic [15:0] held_addr [2];
    logic [7:0]  held_data [2];
    txn_t        lg        [2][16];
    int          nlg       [2];
    int          done_cyc  [2][16];
    int          ndone     [2];
    int          rwd_cyc   [2];
    int          n_rwd     [2];
    int          rwd_res   [2];
    int          rel_cyc   [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural driver + E2PROM: every exec answers with done LAT cycles later
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                busy[k] = 0; i_done[k] = 0; i_ack[k] = 0; i_data_r[k] = 0;
                exec_prev[k] = 0; rwd_prev[k] = 0;
                held_rh[k] = 0; held_addr[k] = 0; held_data[k] = 0;
            end else begin
                i_done[k] = 0;
                i_ack[k]  = 0;
                if (busy[k]) begin
                    tmr[k]--;
                    if (tmr[k] == 0) begin
                        busy[k]   = 0;
                        i_done[k] = 1;
                        if (ndone[k] < 16) done_cyc[k][ndone[k]] = cyc;
                        ndone[k]++;
                        if (cur_rh[k] != 0) begin
                            i_data_r[k] = (mode[k] == MODE_MISM && cur_addr[k] == 2) ?
                                          8'hFF : mem[k][cur_addr[k] & 3];
                        end else begin
                            mem[k][cur_addr[k] & 3] = cur_data[k];
                            i_ack[k] = (mode[k] == MODE_NACK && nwr[k] == 2);
                            if (spur_en[k] && nwr[k] == 1) spur_at[k] = cyc + 4;
                        end
                    end
                end
                if (spur_at[k] == cyc) begin
                    i_done[k] = 1; i_ack[k] = 1; i_data_r[k] = 8'hFF;
                    spur_seen[k]++;
                end
                if (i_exec[k]) begin
                    chk("exec_width", int'(exec_prev[k]), 0);
                    chk("exec_while_busy", int'(busy[k]), 0);
                    if (nlg[k] < 16)
                        lg[k][nlg[k]] = '{rh: int'(i_rh_wl[k]), addr: int'(i_addr[k]),
                                          data: int'(i_data_w[k]), cyc: cyc};
                    nlg[k]++;
                    busy[k] = 1; tmr[k] = LAT;
                    cur_rh[k] = int'(i_rh_wl[k]); cur_addr[k] = int'(i_addr[k]);
                    cur_data[k] = i_data_w[k];
                    if (!i_rh_wl[k]) nwr[k]++;
                    held_rh[k] = i_rh_wl[k]; held_addr[k] = i_addr[k]; held_data[k] = i_data_w[k];
                end else if (i_rh_wl[k] !== held_rh[k] || i_addr[k] !== held_addr[k] ||
                             i_data_w[k] !== held_data[k]) begin
                    hold_bad[k] = 1;
                end
                if (rw_done[k]) begin
                    chk("rw_done_width", int'(rwd_prev[k]), 0);
                    n_rwd[k]++;
                    rwd_cyc[k] = cyc;
                    rwd_res[k] = int'(rw_result[k]);
                end
                exec_prev[k] = i_exec[k];
                rwd_prev[k]  = rw_done[k];
            end
        end
    end

    task automatic clear_log(input int k);
        nlg[k] = 0; ndone[k] = 0; n_rwd[k] = 0; nwr[k] = 0; hold_bad[k] = 0;
        spur_at[k] = -1; spur_seen[k] = 0; rwd_cyc[k] = 0; rwd_res[k] = -1;
        for (int i = 0; i < 4; i++) mem[k][i] = 8'hEE;
    endtask

    task automatic restart(input int k);
        rst_n[k] = 1'b0;
        repeat (3) @(negedge clk);
        clear_log(k);
        @(negedge clk);
        #1 rst_n[k] = 1'b1;
        rel_cyc[k] = cyc;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n;
        n = 0;
        while (n_rwd[k] == 0 && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        chk("rw_done_timeout", int'(n_rwd[k] > 0), 1);
    endtask

    task automatic chk_outputs_zero(input int k, input string tag);
        chk({tag, "_exec"},      int'(i_exec[k]),    0);
        chk({tag, "_rh_wl"},     int'(i_rh_wl[k]),   0);
        chk({tag, "_addr"},      int'(i_addr[k]),    0);
        chk({tag, "_data_w"},    int'(i_data_w[k]),  0);
        chk({tag, "_rw_done"},   int'(rw_done[k]),   0);
        chk({tag, "_rw_result"}, int'(rw_result[k]), 0);
    endtask

    vec_t pass_tbl [8];

    initial begin
        pass_tbl[0] = '{0, 0, 0};  pass_tbl[1] = '{0, 1, 1};
        pass_tbl[2] = '{0, 2, 2};  pass_tbl[3] = '{0, 3, 3};
        pass_tbl[4] = '{1, 0, -1}; pass_tbl[5] = '{1, 1, -1};
        pass_tbl[6] = '{1, 2, -1}; pass_tbl[7] = '{1, 3, -1};

        checks = 0; errors = 0; cyc = 0;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; i_done[k] = 0; i_ack[k] = 0; i_data_r[k] = 0;
            mode[k] = MODE_OK; spur_en[k] = 0;
            clear_log(k);
        end
        repeat (3) @(negedge clk); #2;
        chk_outputs_zero(0, "reset");

        // Clean pass, with a spurious done injected during the first write gap
        mode[0] = MODE_OK; spur_en[0] = 1;
        restart(0);
        wait_done(0, 2000);
        spur_en[0] = 0;
        chk("pass_txn_count", nlg[0], 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pass_rh_%0d", i),   lg[0][i].rh,   pass_tbl[i].rh);
            chk($sformatf("pass_addr_%0d", i), lg[0][i].addr, pass_tbl[i].addr);
            if (pass_tbl[i].data >= 0)
                chk($sformatf("pass_data_%0d", i), lg[0][i].data, pass_tbl[i].data);
        end
        chk("pass_first_exec", lg[0][0].cyc - rel_cyc[0], START + 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wr_gap_%0d", i), lg[0][i+1].cyc - done_cyc[0][i], WR_WAIT + 2);
        for (int i = 4; i < 7; i++)
            chk($sformatf("rd_spacing_%0d", i), lg[0][i+1].cyc - done_cyc[0][i], 2);
        chk("spurious_injected", spur_seen[0], 1);
        chk("pass_ndone_real", ndone[0], 8);
        chk("pass_rwd_count", n_rwd[0], 1);
        chk("pass_result", rwd_res[0], 1);
        chk("pass_rwd_latency", rwd_cyc[0] - done_cyc[0][7], 1);
        chk("pass_hold", int'(hold_bad[0]), 0);
        repeat (1000) @(negedge clk); #2;
        chk("pass_no_more_exec", nlg[0], 8);
        chk("pass_result_held", int'(rw_result[0]), 1);
        chk("pass_done_low", int'(rw_done[0]), 0);

        // Read data mismatch at address 2
        mode[0] = MODE_MISM;
        restart(0);
        wait_done(0, 2000);
        chk("mism_txn_count", nlg[0], 7);
        chk("mism_last_rh", lg[0][6].rh, 1);
        chk("mism_last_addr", lg[0][6].addr, 2);
        chk("mism_result", rwd_res[0], 0);
        chk("mism_rwd_latency", rwd_cyc[0] - done_cyc[0][6], 1);
        repeat (100) @(negedge clk); #2;
        chk("mism_no_more_exec", nlg[0], 7);

        // NACK on the second write
        mode[0] = MODE_NACK;
        restart(0);
        wait_done(0, 2000);
        chk("nack_txn_count", nlg[0], 2);
        chk("nack_result", rwd_res[0], 0);
        chk("nack_rwd_latency", rwd_cyc[0] - done_cyc[0][1], 1);
        repeat (200) @(negedge clk); #2;
        chk("nack_no_more_exec", nlg[0], 2);
        chk("nack_hold", int'(hold_bad[0]), 0);

        // Asynchronous reset while the read of address 1 is outstanding
        mode[0] = MODE_OK;
        restart(0);
        begin
            int n;
            n = 0;
            while (nlg[0] < 6 && n < 2000) begin
                @(negedge clk); #2;
                n++;
            end
            chk("midrd_reached", int'(nlg[0] >= 6), 1);
        end
        repeat (5) @(negedge clk);
        #3 rst_n[0] = 1'b0;
        #1 chk_outputs_zero(0, "midrd_async");
        repeat (2) @(negedge clk);
        clear_log(0);
        @(negedge clk);
        #1 rst_n[0] = 1'b1;
        rel_cyc[0] = cyc;
        wait_done(0, 2000);
        chk("rst_first_exec", lg[0][0].cyc - rel_cyc[0], START + 1);
        chk("rst_first_rh", lg[0][0].rh, 0);
        chk("rst_first_addr", lg[0][0].addr, 0);
        chk("rst_txn_count", nlg[0], 8);
        chk("rst_result", rwd_res[0], 1);

        // Single-byte configuration
        mode[1] = MODE_OK;
        restart(1);
        wait_done(1, 2000);
        chk("one_txn_count", nlg[1], 2);
        chk("one_wr_rh", lg[1][0].rh, 0);
        chk("one_wr_addr", lg[1][0].addr, 0);
        chk("one_wr_data", lg[1][0].data, 0);
        chk("one_rd_rh", lg[1][1].rh, 1);
        chk("one_rd_addr", lg[1][1].addr, 0);
        chk("one_gap", lg[1][1].cyc - done_cyc[1][0], WR_WAIT + 2);
        chk("one_result", rwd_res[1], 1);
        chk("one_rwd_latency", rwd_cyc[1] - done_cyc[1][1], 1);
        repeat (100) @(negedge clk); #2;
        chk("one_no_more_exec", nlg[1], 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
